// File: rtl/shift_sched_pkg.sv
// Shared definitions for the shift_sched controller: datapath widths,
// per-pass shift limit and the controller state encoding.
package shift_sched_pkg;

    localparam int DATA_W   = 8;  // operand width, matches the shifter datapath
    localparam int AMT_W    = 4;  // job shift-amount width (0..15)
    localparam int STEP_MAX = 7;  // largest amount the shifter takes in one pass
    localparam int STEP_W   = 3;  // width of the shifter amount port

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sched_if.sv
// Job request / result response bundle for shift_sched.
//   req_valid/req_ready : per-requester handshake, bit i = requester i
//   req_data/amt/dir    : per-requester operand, shift amount, direction (1 = right)
//   rsp_valid/rsp_ready : result handshake
//   rsp_data/rsp_id     : shifted result and owning requester
//   busy                : controller is not idle
// master = requesters + response consumer, slave = controller.
interface shift_sched_if;
    import shift_sched_pkg::*;

    logic [1:0]                   req_valid;
    logic [1:0]                   req_ready;
    logic [1:0][DATA_W-1:0]       req_data;
    logic [1:0][AMT_W-1:0]        req_amt;
    logic [1:0]                   req_dir;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [DATA_W-1:0]            rsp_data;
    logic                         rsp_id;
    logic                         busy;

    modport master (
        output req_valid, req_data, req_amt, req_dir, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_amt, req_dir, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

endinterface

// File: rtl/shift_sched_barrel_shifter.sv
// Combinational 8-bit logical barrel shifter, one evaluation per pass.
//   a   : operand
//   amt : shift amount 0..7
//   dir : 0 = left, 1 = right (zero fill both ways, no rotation)
//   y   : shifted result
module BarrelShifter
    import shift_sched_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [STEP_W-1:0] amt,
    input  logic              dir,
    output logic [DATA_W-1:0] y
);

    assign y = dir ? (a >> amt) : (a << amt);

endmodule

// File: rtl/shift_sched.sv
// Two-requester shift-job controller. A round-robin arbiter accepts one job
// at a time, the job amount (0..15) is applied as repeated passes of at most
// STEP_MAX through a single barrel shifter, and the result is presented on
// the response port until the consumer accepts it.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, discards any in-flight job
//   bus   : shift_sched_if slave modport (requests, response, busy)
module shift_sched
    import shift_sched_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    shift_sched_if.slave  bus
);

    state_t             state_q;
    state_t             state_d;
    logic               ptr_q;     // requester with priority on the next grant
    logic [DATA_W-1:0]  acc_q;     // partially shifted operand
    logic [AMT_W-1:0]   rem_q;     // shift amount still to apply
    logic               dir_q;
    logic               id_q;

    logic               grant_valid;
    logic               grant_id;
    logic               accept;
    logic [STEP_W-1:0]  step;
    logic [AMT_W-1:0]   rem_next;
    logic [DATA_W-1:0]  shift_y;

    // Arbiter: the pointer's requester wins, otherwise the other one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        grant_valid = 1'b0;
        grant_id    = ptr_q;
        if (bus.req_valid[ptr_q]) begin
            grant_valid = 1'b1;
            grant_id    = ptr_q;
        end else if (bus.req_valid[~ptr_q]) begin
            grant_valid = 1'b1;
            grant_id    = ~ptr_q;
        end
    end

    assign accept = (state_q == IDLE) && grant_valid;

    // Largest pass the shifter can take; an amount of 0 gives one step-0 pass.
    always_comb begin
        if (rem_q > AMT_W'(STEP_MAX)) begin
            step = STEP_W'(STEP_MAX);
        end else begin
            step = rem_q[STEP_W-1:0];
        end
    end

    assign rem_next = rem_q - AMT_W'(step);

    BarrelShifter u_shifter (
        .a   (acc_q),
        .amt (step),
        .dir (dir_q),
        .y   (shift_y)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (rem_next == '0) state_d = DONE;
            DONE:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Job registers. All are reset so an aborted job leaves nothing behind
    // and the response outputs come up at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are a handful of flops, not a memory, so each is given
        // an explicit reset value.
        if (!rst_n) begin
            ptr_q <= 1'b0;
            acc_q <= '0;
            rem_q <= '0;
            dir_q <= 1'b0;
            id_q  <= 1'b0;
        end else begin
            if (accept) begin
                acc_q <= bus.req_data[grant_id];
                rem_q <= bus.req_amt[grant_id];
                dir_q <= bus.req_dir[grant_id];
                id_q  <= grant_id;
                ptr_q <= ~grant_id;
            end else if (state_q == SHIFT) begin
                acc_q <= shift_y;
                rem_q <= rem_next;
            end
        end
    end

    // Outputs.
    always_comb begin
        bus.req_ready = '0;
        if ((state_q == IDLE) && grant_valid) begin
            bus.req_ready[grant_id] = 1'b1;
        end
        bus.rsp_valid = (state_q == DONE);
        bus.rsp_data  = (state_q == DONE) ? acc_q : '0;
        bus.rsp_id    = (state_q == DONE) ? id_q : 1'b0;
        bus.busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched: a table of single jobs with
// hand-computed results and pass counts, then arbitration, backpressure
// and mid-job reset sequences.
module tb_shift_sched;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   both_hi;

    shift_sched_if bus ();

    shift_sched u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // req_ready must never grant both requesters.
    always @(negedge clk) begin
        if (bus.req_ready == 2'b11) both_hi++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic [3:0] amt;
        logic       dir;
        logic [7:0] exp;
        int         passes;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) until rsp_valid, counting busy cycles before it.
    task automatic wait_rsp(output int passes);
        passes = 0;
        while (!bus.rsp_valid && passes < 10) begin
            if (bus.busy) passes++;
            @(posedge clk);
            #1;
        end
        check("rsp_timeout", {31'd0, bus.rsp_valid}, 32'd1);
    endtask

    // Submits one job on a single requester and collects its response.
    // Called #1 after a rising edge with the controller idle.
    task automatic run_job(input vec_t v, input string tag);
        int n;
        int p;
        bus.req_data[v.id] = v.data;
        bus.req_amt[v.id]  = v.amt;
        bus.req_dir[v.id]  = v.dir;
        bus.req_valid      = 2'b00;
        bus.req_valid[v.id] = 1'b1;
        bus.rsp_ready      = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[v.id] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_accept"}, {31'd0, bus.req_ready[v.id]}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        wait_rsp(p);
        check({tag, "_data"}, {24'd0, bus.rsp_data}, {24'd0, v.exp});
        check({tag, "_id"}, {31'd0, bus.rsp_id}, {31'd0, v.id});
        check({tag, "_passes"}, p, v.passes);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        int   p;
        logic g;
        checks  = 0;
        errors  = 0;
        both_hi = 0;
        bus.req_valid = 2'b00;
        bus.req_data  = '0;
        bus.req_amt   = '0;
        bus.req_dir   = 2'b00;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;

        vecs[0]  = '{1'b0, 8'h01, 4'd3,  1'b0, 8'h08, 1};
        vecs[1]  = '{1'b1, 8'h80, 4'd9,  1'b1, 8'h00, 2};
        vecs[2]  = '{1'b1, 8'hF0, 4'd15, 1'b0, 8'h00, 3};
        vecs[3]  = '{1'b1, 8'hA5, 4'd0,  1'b0, 8'hA5, 1};
        vecs[4]  = '{1'b0, 8'hFF, 4'd7,  1'b0, 8'h80, 1};
        vecs[5]  = '{1'b1, 8'hC3, 4'd14, 1'b1, 8'h00, 2};
        vecs[6]  = '{1'b0, 8'hB3, 4'd8,  1'b0, 8'h00, 2};
        vecs[7]  = '{1'b1, 8'h3C, 4'd1,  1'b1, 8'h1E, 1};
        vecs[8]  = '{1'b0, 8'h80, 4'd0,  1'b1, 8'h80, 1};
        vecs[9]  = '{1'b0, 8'h80, 4'd1,  1'b1, 8'h40, 1};
        vecs[10] = '{1'b0, 8'h80, 4'd2,  1'b1, 8'h20, 1};
        vecs[11] = '{1'b0, 8'h80, 4'd3,  1'b1, 8'h10, 1};
        vecs[12] = '{1'b0, 8'h80, 4'd4,  1'b1, 8'h08, 1};
        vecs[13] = '{1'b0, 8'h80, 4'd5,  1'b1, 8'h04, 1};
        vecs[14] = '{1'b0, 8'h80, 4'd6,  1'b1, 8'h02, 1};
        vecs[15] = '{1'b0, 8'h80, 4'd7,  1'b1, 8'h01, 1};

        // Reset state, including req_ready with ptr at requester 0.
        #12;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
        check("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        check("rst_ready_none", {30'd0, bus.req_ready}, 32'd0);
        bus.req_valid = 2'b11;
        #1;
        check("rst_ready_both", {30'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 2'b10;
        #1;
        check("rst_ready_r1", {30'd0, bus.req_ready}, 32'd2);
        do_reset();

        // Table of single jobs.
        for (int i = 0; i < 16; i++) begin
            run_job(vecs[i], $sformatf("vec%0d", i));
        end

        // Arbitration: both requesters valid continuously from reset.
        do_reset();
        bus.req_data[0] = 8'h11; bus.req_amt[0] = 4'd1; bus.req_dir[0] = 1'b0;
        bus.req_data[1] = 8'h11; bus.req_amt[1] = 4'd2; bus.req_dir[1] = 1'b0;
        bus.req_valid   = 2'b11;
        bus.rsp_ready   = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (bus.req_ready == 2'b00 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("arb_onehot", $countones(bus.req_ready), 1);
            g = bus.req_ready[1];
            check($sformatf("arb_grant%0d", k), {31'd0, g}, (k % 2));
            @(posedge clk);
            #1;
            wait_rsp(p);
            check("arb_rsp_id", {31'd0, bus.rsp_id}, {31'd0, g});
            check("arb_rsp_data", {24'd0, bus.rsp_data}, g ? 32'h44 : 32'h22);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 2'b00;
        check("arb_never_both", both_hi, 0);

        // Backpressure: response held while rsp_ready is low.
        @(posedge clk);
        #1;
        bus.rsp_ready   = 1'b0;
        bus.req_data[0] = 8'h0F; bus.req_amt[0] = 4'd2; bus.req_dir[0] = 1'b0;
        bus.req_valid   = 2'b01;
        #1;
        check("bp_accept", {30'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_data[1] = 8'h01; bus.req_amt[1] = 4'd1; bus.req_dir[1] = 1'b0;
        bus.req_valid   = 2'b10;
        wait_rsp(p);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_data", {24'd0, bus.rsp_data}, 32'h3C);
            check("bp_id", {31'd0, bus.rsp_id}, 32'd0);
            check("bp_ready", {30'd0, bus.req_ready}, 32'd0);
            check("bp_busy", {31'd0, bus.busy}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_busy", {31'd0, bus.busy}, 32'd0);
        check("bp_release_ready", {30'd0, bus.req_ready}, 32'd2);
        @(posedge clk);
        #1;
        check("bp_next_grant", {31'd0, bus.busy}, 32'd1);
        bus.req_valid = 2'b00;
        wait_rsp(p);
        check("bp_next_data", {24'd0, bus.rsp_data}, 32'h02);
        check("bp_next_id", {31'd0, bus.rsp_id}, 32'd1);
        @(posedge clk);
        #1;

        // Reset during the second pass of an amt=12 job.
        do_reset();
        bus.req_data[0] = 8'hFF; bus.req_amt[0] = 4'd12; bus.req_dir[0] = 1'b0;
        bus.req_valid   = 2'b01;
        bus.rsp_ready   = 1'b1;
        #1;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
        check("mid_busy_before", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mid_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) n++;
        end
        check("mid_no_rsp", n, 0);
        bus.req_valid = 2'b11;
        #1;
        check("mid_ptr_restart", {30'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 2'b00;
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
